// File: rtl/uart_tx_pattern_gen.sv
// uart_tx_pattern_gen: periodic burst traffic source for uart_byte_tx bring-up and soak tests.
// Every PERIOD clocks a burst of BURST_LEN words is sent in one of four patterns, each word
// handshaken on tx_done. Define UART_PATGEN_CHKSUM_EN to append a checksum word to each burst.
module uart_tx_pattern_gen #(
  parameter int unsigned PERIOD    = 50_000_000,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned DATA_W    = 8,
  parameter logic [15:0] FIXED_VAL = 16'h0055,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              tx_done,
  output logic              send_en,
  output logic [DATA_W-1:0] data_byte,
  output logic              busy,
  output logic [15:0]       burst_cnt,
  output logic              tx_err,
  output logic              overrun
);

  localparam int unsigned TimerW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam int unsigned IdxW   = 8;

  localparam logic [TimerW-1:0] TimerMax = TimerW'(PERIOD - 1);
  localparam logic [WaitW-1:0]  WaitMax  = WaitW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(BURST_LEN - 1);
  localparam logic [15:0]       LfsrSeed = 16'hACE1;

  typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q;
  logic              tick_q;
  logic [1:0]        mode_q, mode_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [DATA_W-1:0] inc_q, inc_d;
  logic [DATA_W-1:0] walk_q, walk_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              send_q, send_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;
  // High while the word in flight is pattern data (as opposed to the checksum word).
  logic              data_word;

`ifdef UART_PATGEN_CHKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  assign data_word = (idx_q != IdxW'(BURST_LEN));
`else
  assign data_word = 1'b1;
`endif

  function automatic logic [DATA_W-1:0] pattern_word(input logic [1:0]        m,
                                                     input logic [DATA_W-1:0] inc,
                                                     input logic [DATA_W-1:0] walk,
                                                     input logic [15:0]       lfsr);
    case (m)
      2'd0:    return inc;
      2'd1:    return walk;
      2'd2:    return lfsr[DATA_W-1:0];
      default: return FIXED_VAL[DATA_W-1:0];
    endcase
  endfunction

  // Period timer; tick is registered so the first burst starts PERIOD+1 clocks after enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= enable && (timer_q == TimerMax);
      if (!enable || timer_q == TimerMax) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TimerW'(1);
      end
    end
  end

  // Burst FSM next-state, pattern advance and registered output values.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    inc_d   = inc_q;
    walk_d  = walk_q;
    lfsr_d  = lfsr_q;
    send_d  = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
`ifdef UART_PATGEN_CHKSUM_EN
    sum_d   = sum_q;
`endif
    // A tick during a burst is dropped but remembered.
    if (tick_q && busy_q) ovr_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (tick_q) begin
          state_d = StSend;
          mode_d  = mode;
          idx_d   = '0;
          send_d  = 1'b1;
          busy_d  = 1'b1;
          data_d  = pattern_word(mode, inc_q, walk_q, lfsr_q);
`ifdef UART_PATGEN_CHKSUM_EN
          sum_d   = data_d;
`endif
        end
      end
      StSend: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        if (tx_done) begin
          // The checksum word never advances pattern state.
          if (data_word) begin
            case (mode_q)
              2'd0:    inc_d  = inc_q + DATA_W'(1);
              2'd1:    walk_d = (walk_q << 1) | (walk_q >> (DATA_W - 1));
              2'd2:    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
              default: ;
            endcase
          end
          idx_d = idx_q + IdxW'(1);
          if (data_word && idx_q != LastIdx) begin
            state_d = StSend;
            send_d  = 1'b1;
            data_d  = pattern_word(mode_q, inc_d, walk_d, lfsr_d);
`ifdef UART_PATGEN_CHKSUM_EN
            sum_d   = sum_q + data_d;
`endif
          end
`ifdef UART_PATGEN_CHKSUM_EN
          else if (data_word) begin
            state_d = StSend;
            send_d  = 1'b1;
            data_d  = sum_q;
          end
`endif
          else begin
            state_d = StIdle;
            busy_d  = 1'b0;
            cnt_d   = cnt_q + 16'd1;
          end
        end else if (wait_q == WaitMax) begin
          // Abort: pattern untouched so the next burst resends this word.
          state_d = StIdle;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pattern and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      idx_q   <= '0;
      wait_q  <= '0;
      inc_q   <= '0;
      walk_q  <= DATA_W'(1);
      lfsr_q  <= LfsrSeed;
      send_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      inc_q   <= inc_d;
      walk_q  <= walk_d;
      lfsr_q  <= lfsr_d;
      send_q  <= send_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef UART_PATGEN_CHKSUM_EN
  // Running sum of the burst's data words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  assign send_en   = send_q;
  assign data_byte = data_q;
  assign busy      = busy_q;
  assign burst_cnt = cnt_q;
  assign tx_err    = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_tx_pattern_gen.sv
// Directed bench for uart_tx_pattern_gen: patterns, timing, timeout, overrun, enable drop, reset.
module tb_uart_tx_pattern_gen;

`ifdef UART_PATGEN_CHKSUM_EN
  localparam int Gap2 = 300;
`else
  localparam int Gap2 = 200;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        enable2 = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  mode2 = 2'd0;
  logic        tx_done = 1'b0;
  logic        tx_done2 = 1'b0;
  logic        send_en, send_en2;
  logic [7:0]  data_byte, data_byte2;
  logic        busy, busy2;
  logic [15:0] burst_cnt, burst_cnt2;
  logic        tx_err, tx_err2;
  logic        overrun, overrun2;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int send_count = 0;
  int hold_at = -1;
  int hold_cyc = 0;
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];
  int send2_cyc[$];

  uart_tx_pattern_gen #(
    .PERIOD   (100),
    .BURST_LEN(3),
    .DATA_W   (8),
    .FIXED_VAL(16'h0055),
    .TIMEOUT  (50)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .mode     (mode),
    .tx_done  (tx_done),
    .send_en  (send_en),
    .data_byte(data_byte),
    .busy     (busy),
    .burst_cnt(burst_cnt),
    .tx_err   (tx_err),
    .overrun  (overrun)
  );

  uart_tx_pattern_gen #(
    .PERIOD   (100),
    .BURST_LEN(3),
    .DATA_W   (8),
    .FIXED_VAL(16'h0055),
    .TIMEOUT  (1000)
  ) dut_ovr (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable2),
    .mode     (mode2),
    .tx_done  (tx_done2),
    .send_en  (send_en2),
    .data_byte(data_byte2),
    .busy     (busy2),
    .burst_cnt(burst_cnt2),
    .tx_err   (tx_err2),
    .overrun  (overrun2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_burst(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
`ifdef UART_PATGEN_CHKSUM_EN
    exp_q.push_back(8'(a + b + c));
`endif
  endtask

  task automatic check_words(input string tag);
    logic [31:0] got;
    check_eq({tag, "_count"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < sent_q.size()) ? 32'(sent_q[i]) : 'x;
      check_eq($sformatf("%s_w%0d", tag, i), got, 32'(exp_q[i]));
    end
    sent_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_bursts(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (burst_cnt != target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, burst_cnt, target);
  endtask

  // Transmitter model for dut: tx_done 10 cycles after send_en, optionally withheld once.
  initial begin : tx_model
    forever begin
      @(posedge clk);
      #1;
      while (send_en) begin
        sent_q.push_back(data_byte);
        send_count++;
        if (send_count - 1 == hold_at) begin
          hold_cyc = cyc;
          @(posedge clk);
          #1;
        end else begin
          repeat (10) @(posedge clk);
          #1 tx_done = 1'b1;
          if (reset_n) check_eq("data_stable", data_byte, sent_q[$]);
          @(posedge clk);
          #1 tx_done = 1'b0;
        end
      end
    end
  end

  // Slow transmitter model for dut_ovr: tx_done 60 cycles after send_en.
  initial begin : tx_model2
    forever begin
      @(posedge clk);
      #1;
      while (send_en2) begin
        send2_cyc.push_back(cyc);
        repeat (60) @(posedge clk);
        #1 tx_done2 = 1'b1;
        @(posedge clk);
        #1 tx_done2 = 1'b0;
      end
    end
  end

  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_send_en", send_en, 1'b0);
    check_eq("rst_data", data_byte, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_burst_cnt", burst_cnt, 16'd0);
    check_eq("rst_tx_err", tx_err, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);

    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) enable = 1'b1;
    n = 0;
    while (!send_en && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("first_send_latency", n, 101);
    check_eq("busy_with_send", busy, 1'b1);

    // Increment pattern, two bursts.
    wait_bursts(16'd2, 400, "mode0_bursts");
    expect_burst(8'h00, 8'h01, 8'h02);
    expect_burst(8'h03, 8'h04, 8'h05);
    check_words("mode0");
    check_eq("mode0_tx_err", tx_err, 1'b0);
    check_eq("mode0_overrun", overrun, 1'b0);

    // Walking one, three bursts.
    mode = 2'd1;
    wait_bursts(16'd5, 500, "mode1_bursts");
    expect_burst(8'h01, 8'h02, 8'h04);
    expect_burst(8'h08, 8'h10, 8'h20);
    expect_burst(8'h40, 8'h80, 8'h01);
    check_words("mode1");

    // PRBS from seed 0xACE1: states ACE1, 5670, AB38.
    mode = 2'd2;
    wait_bursts(16'd6, 200, "mode2_bursts");
    expect_burst(8'hE1, 8'h70, 8'h38);
    check_words("mode2");

    mode = 2'd3;
    wait_bursts(16'd7, 200, "mode3_bursts");
    expect_burst(8'h55, 8'h55, 8'h55);
    check_words("mode3");

    // Withhold tx_done on the 2nd word of the next burst.
    mode = 2'd0;
    hold_at = send_count + 1;
    n = 0;
    while (!tx_err && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("tx_err_set", tx_err, 1'b1);
    check_eq("tx_err_latency", cyc - hold_cyc, 51);
    check_eq("timeout_busy", busy, 1'b0);
    check_eq("timeout_burst_cnt", burst_cnt, 16'd7);
    wait_bursts(16'd8, 200, "resend_bursts");
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h07);
    expect_burst(8'h07, 8'h08, 8'h09);
    check_words("timeout_resend");

    // Drop enable right after a burst starts: burst completes, then silence.
    n = 0;
    while (!send_en && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    enable = 1'b0;
    wait_bursts(16'd9, 100, "enable_drop_burst");
    expect_burst(8'h0A, 8'h0B, 8'h0C);
    check_words("enable_drop");
    n = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (send_en) n++;
    end
    check_eq("disabled_no_send", n, 0);
    check_eq("disabled_burst_cnt", burst_cnt, 16'd9);

    // Slow transmitter on dut_ovr: burst overlaps a tick.
    enable2 = 1'b1;
    n = 0;
    while (burst_cnt2 != 16'd1 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("ovr_burst_cnt", burst_cnt2, 16'd1);
    check_eq("ovr_overrun", overrun2, 1'b1);
    check_eq("ovr_tx_err", tx_err2, 1'b0);
    n = 0;
    while (send2_cyc.size() < (Gap2 == 300 ? 5 : 4) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("ovr_next_burst_gap",
             (send2_cyc.size() >= (Gap2 == 300 ? 5 : 4)) ?
               send2_cyc[send2_cyc.size() - 1] - send2_cyc[0] : -1,
             Gap2);

    // Asynchronous reset in the middle of a burst.
    enable = 1'b1;
    n = 0;
    while (!send_en && n < 250) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("pre_reset_send", send_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_send_en", send_en, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_data", data_byte, 8'h00);
    check_eq("arst_burst_cnt", burst_cnt, 16'd0);
    check_eq("arst_tx_err", tx_err, 1'b0);
    check_eq("arst_overrun2", overrun2, 1'b0);
    n = 0;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (send_en) n++;
    end
    check_eq("reset_no_send", n, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
